// File: rtl/fir_accumulator.sv
// Accumulates NTAPS signed 48-bit products per output sample, then rounds
// half-up, drops FRAC fraction bits and saturates to a signed 16-bit result.
module fir_accumulator #(
    parameter int FRAC  = 15,
    parameter int NTAPS = 32,
    parameter int ACC_W = 56
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic signed [47:0] prod_in,
    input  logic               prod_valid,
    input  logic               y_ready,
    output logic signed [15:0] y_out,
    output logic               y_valid,
    output logic               sat_flag,
    output logic               busy
);

    localparam int CNT_W = $clog2(NTAPS + 1);
    localparam logic [CNT_W-1:0]        LAST = CNT_W'(NTAPS);
    localparam logic signed [ACC_W-1:0] HALF = ACC_W'(1) << (FRAC - 1);
    localparam logic signed [ACC_W-1:0] MAXV = ACC_W'(32767);
    localparam logic signed [ACC_W-1:0] MINV = -ACC_W'(32768);

    typedef enum logic [1:0] {IDLE, ACCUM, ROUND, DONE} state_t;

    state_t                  state, state_nxt;
    logic signed [ACC_W-1:0] acc;
    logic [CNT_W-1:0]        cnt;
    logic                    full;
    logic                    clr;
    logic                    add;
    logic signed [ACC_W-1:0] sum;
    logic signed [ACC_W-1:0] rnd;

    assign full = (cnt == LAST);

    // A start is honoured everywhere except a DONE that is still stalled.
    assign clr = start && ((state != DONE) || y_ready);
    // Once the counter is full, ACCUM spends one cycle draining before ROUND.
    assign add = (state == ACCUM) && !start && !full && prod_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  if (start) state_nxt = ACCUM;
            ACCUM: if (start) state_nxt = ACCUM;
                   else if (full) state_nxt = ROUND;
            ROUND: state_nxt = start ? ACCUM : DONE;
            DONE:  if (y_ready) state_nxt = start ? ACCUM : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy    = (state == ACCUM) || (state == ROUND);
        y_valid = (state == DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc <= '0;
            cnt <= '0;
        end else if (clr) begin
            acc <= '0;
            cnt <= '0;
        end else if (add) begin
            acc <= acc + {{(ACC_W-48){prod_in[47]}}, prod_in};
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign sum = acc + HALF;
    assign rnd = sum >>> FRAC;

    // Result registers only load from an un-aborted ROUND, so they hold through DONE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y_out    <= '0;
            sat_flag <= 1'b0;
        end else if ((state == ROUND) && !start) begin
            if (rnd > MAXV) begin
                y_out    <= 16'sh7fff;
                sat_flag <= 1'b1;
            end else if (rnd < MINV) begin
                y_out    <= -16'sh8000;
                sat_flag <= 1'b1;
            end else begin
                y_out    <= rnd[15:0];
                sat_flag <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_fir_accumulator.sv
// Directed bench for fir_accumulator at NTAPS=4, FRAC=15 with hand-computed results.
module tb_fir_accumulator;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               start = 1'b0;
    logic signed [47:0] prod_in = '0;
    logic               prod_valid = 1'b0;
    logic               y_ready = 1'b0;
    logic signed [15:0] y_out;
    logic               y_valid;
    logic               sat_flag;
    logic               busy;

    int vectors = 0;
    int miscompares = 0;

    localparam logic signed [47:0] P1   = 48'sd32768;
    localparam logic signed [47:0] BIG  = 48'sd1073741824;

    fir_accumulator #(.FRAC(15), .NTAPS(4), .ACC_W(56)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .prod_in(prod_in),
        .prod_valid(prod_valid), .y_ready(y_ready), .y_out(y_out),
        .y_valid(y_valid), .sat_flag(sat_flag), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_start;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic feed(input logic signed [47:0] v);
        prod_in    = v;
        prod_valid = 1'b1;
        tick();
        prod_valid = 1'b0;
        prod_in    = '0;
    endtask

    // Start, four products, then two edges so the result is in DONE.
    task automatic sample4(input logic signed [47:0] a, input logic signed [47:0] b,
                           input logic signed [47:0] c, input logic signed [47:0] d);
        do_start();
        feed(a); feed(b); feed(c); feed(d);
        tick();
        tick();
    endtask

    task automatic accept;
        y_ready = 1'b1;
        tick();
        y_ready = 1'b0;
    endtask

    task automatic test_reset;
        #1;
        vectors++; if (y_out !== 16'sd0) begin miscompares++; $display("FAIL reset_y_out: got %0d expected 0", y_out); end
        vectors++; if (y_valid !== 1'b0) begin miscompares++; $display("FAIL reset_y_valid: got %b expected 0", y_valid); end
        vectors++; if (sat_flag !== 1'b0) begin miscompares++; $display("FAIL reset_sat_flag: got %b expected 0", sat_flag); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b expected 0", busy); end
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_unity_sum;
        do_start();
        vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL first_start_busy: got %b expected 1", busy); end
        feed(P1); feed(P1); feed(P1); feed(P1);
        vectors++; if (y_valid !== 1'b0) begin miscompares++; $display("FAIL latency_t1: got %b expected 0", y_valid); end
        tick();
        vectors++; if (y_valid !== 1'b0) begin miscompares++; $display("FAIL latency_t1b: got %b expected 0", y_valid); end
        tick();
        vectors++; if (y_valid !== 1'b1) begin miscompares++; $display("FAIL latency_t2: got %b expected 1", y_valid); end
        vectors++; if (y_out !== 16'sd4) begin miscompares++; $display("FAIL unity_y_out: got %0d expected 4", y_out); end
        vectors++; if (sat_flag !== 1'b0) begin miscompares++; $display("FAIL unity_sat: got %b expected 0", sat_flag); end
        accept();
        vectors++; if (y_valid !== 1'b0) begin miscompares++; $display("FAIL unity_accept: got %b expected 0", y_valid); end
    endtask

    task automatic test_rounding;
        sample4(48'sd16384, 48'sd0, 48'sd0, 48'sd0);
        vectors++; if (y_out !== 16'sd1) begin miscompares++; $display("FAIL round_half_up: got %0d expected 1", y_out); end
        accept();
        sample4(-48'sd16384, 48'sd0, 48'sd0, 48'sd0);
        vectors++; if (y_out !== 16'sd0) begin miscompares++; $display("FAIL round_neg_half: got %0d expected 0", y_out); end
        accept();
        sample4(-48'sd16385, 48'sd0, 48'sd0, 48'sd0);
        vectors++; if (y_out !== -16'sd1) begin miscompares++; $display("FAIL round_neg_below: got %0d expected -1", y_out); end
        vectors++; if (sat_flag !== 1'b0) begin miscompares++; $display("FAIL round_sat: got %b expected 0", sat_flag); end
        accept();
    endtask

    task automatic test_saturation;
        sample4(BIG, BIG, BIG, BIG);
        vectors++; if (y_out !== 16'sd32767) begin miscompares++; $display("FAIL sat_pos_y: got %0d expected 32767", y_out); end
        vectors++; if (sat_flag !== 1'b1) begin miscompares++; $display("FAIL sat_pos_flag: got %b expected 1", sat_flag); end
        accept();
        sample4(-BIG, -BIG, -BIG, -BIG);
        vectors++; if (y_out !== -16'sd32768) begin miscompares++; $display("FAIL sat_neg_y: got %0d expected -32768", y_out); end
        vectors++; if (sat_flag !== 1'b1) begin miscompares++; $display("FAIL sat_neg_flag: got %b expected 1", sat_flag); end
        accept();
    endtask

    task automatic test_abort;
        do_start();
        feed(P1); feed(P1);
        do_start();
        vectors++; if (y_valid !== 1'b0) begin miscompares++; $display("FAIL abort_no_out: got %b expected 0", y_valid); end
        vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL abort_busy: got %b expected 1", busy); end
        feed(P1); feed(P1); feed(P1); feed(P1);
        tick();
        tick();
        vectors++; if (y_valid !== 1'b1) begin miscompares++; $display("FAIL abort_valid: got %b expected 1", y_valid); end
        vectors++; if (y_out !== 16'sd4) begin miscompares++; $display("FAIL abort_y_out: got %0d expected 4", y_out); end
        accept();
        tick(); tick(); tick();
        vectors++; if (y_valid !== 1'b0) begin miscompares++; $display("FAIL abort_single_out: got %b expected 0", y_valid); end
    endtask

    task automatic test_back_to_back;
        sample4(P1, P1, P1, P1);
        for (int i = 0; i < 5; i++) begin
            start      = (i % 2 == 0);
            prod_valid = 1'b1;
            prod_in    = BIG;
            tick();
            vectors++; if (y_valid !== 1'b1) begin miscompares++; $display("FAIL stall_valid[%0d]: got %b expected 1", i, y_valid); end
            vectors++; if (y_out !== 16'sd4) begin miscompares++; $display("FAIL stall_y_out[%0d]: got %0d expected 4", i, y_out); end
        end
        start      = 1'b0;
        prod_valid = 1'b0;
        prod_in    = '0;
        y_ready    = 1'b1;
        start      = 1'b1;
        tick();
        y_ready    = 1'b0;
        start      = 1'b0;
        vectors++; if (y_valid !== 1'b0) begin miscompares++; $display("FAIL b2b_accepted: got %b expected 0", y_valid); end
        vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL b2b_busy: got %b expected 1", busy); end
        feed(48'sd16384); feed(48'sd0); feed(48'sd0); feed(48'sd0);
        tick();
        tick();
        vectors++; if (y_valid !== 1'b1) begin miscompares++; $display("FAIL b2b_valid: got %b expected 1", y_valid); end
        vectors++; if (y_out !== 16'sd1) begin miscompares++; $display("FAIL b2b_y_out: got %0d expected 1", y_out); end
        accept();
    endtask

    task automatic test_reset_mid_sample;
        do_start();
        feed(P1); feed(P1);
        rst_n = 1'b0;
        #1;
        vectors++; if (y_out !== 16'sd0) begin miscompares++; $display("FAIL mid_rst_y_out: got %0d expected 0", y_out); end
        vectors++; if (y_valid !== 1'b0) begin miscompares++; $display("FAIL mid_rst_valid: got %b expected 0", y_valid); end
        vectors++; if (sat_flag !== 1'b0) begin miscompares++; $display("FAIL mid_rst_sat: got %b expected 0", sat_flag); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL mid_rst_busy: got %b expected 0", busy); end
        tick();
        rst_n = 1'b1;
        tick();
        vectors++; if (y_valid !== 1'b0) begin miscompares++; $display("FAIL mid_rst_no_out: got %b expected 0", y_valid); end
        sample4(P1, P1, P1, P1);
        vectors++; if (y_valid !== 1'b1) begin miscompares++; $display("FAIL post_rst_valid: got %b expected 1", y_valid); end
        vectors++; if (y_out !== 16'sd4) begin miscompares++; $display("FAIL post_rst_y_out: got %0d expected 4", y_out); end
        accept();
    endtask

    initial begin
        test_reset();
        test_unity_sum();
        test_rounding();
        test_saturation();
        test_abort();
        test_back_to_back();
        test_reset_mid_sample();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
